// File: rtl/sisa_pkg.sv
// sCPU shared constants: datapath widths and write-port requester ids.
// Imported by the register write arbiter and its round-robin core.
package sisa_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_NUM_REQ  = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_IMM = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or
// after ptr; ptr moves one past the winner whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

  assign ptr_d = (grant_idx == IW'(N - 1)) ? '0
               : grant_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst)         ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shared write port for the register bank: arbitrate, mux the winner,
// decode its address and register the D bus / enable for one cycle.
module reg_write_arbiter
  import sisa_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         reg_d,
  output logic [NUM_REGS-1:0]       reg_en,
  output logic                      addr_err
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req_eff;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       w;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] en_dec;
  logic                addr_ok;

  logic [DATA_W-1:0]   reg_d_q, reg_d_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic                err_q, err_d;

  // Halt and reset mask requests before arbitration so ptr cannot move.
  assign req_eff = req_valid & {NUM_REQ{rst & ~freeze}};

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk          (clk),
    .rst          (rst),
    .req          (req_eff),
    .advance      (xfer),
    .grant_onehot (gnt),
    .grant_idx    (w)
  );

  assign xfer      = |gnt;
  assign req_ready = gnt;
  assign sel_addr  = req_addr[int'(w)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(w)*DATA_W +: DATA_W];
  assign addr_ok   = int'(sel_addr) < NUM_REGS;

  always_comb begin
    en_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      en_dec[r] = (int'(sel_addr) == r);
    end
  end

  always_comb begin
    reg_d_d  = reg_d_q;
    reg_en_d = '0;
    err_d    = 1'b0;
    if (xfer) begin
      reg_d_d  = sel_data;
      reg_en_d = en_dec;
      err_d    = !addr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_d_q  <= '0;
      reg_en_q <= '0;
      err_q    <= 1'b0;
    end else begin
      reg_d_q  <= reg_d_d;
      reg_en_q <= reg_en_d;
      err_q    <= err_d;
    end
  end

  assign reg_d    = reg_d_q;
  assign reg_en   = reg_en_q;
  assign addr_err = err_q;

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write-port arbiter for a bank of 8-bit register_8bits instances in the sCPU datapath. Several requesters compete for one shared write path: the ALU result, the memory load return and the immediate loader. The block grants one requester per cycle with a valid/ready handshake. It then drives the shared data bus and a one-hot per-register enable from a registered output stage.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- NUM_REGS, 4, number of 8-bit registers in the bank (1..2**ADDR_W)
- DATA_W, 8, data width; must match register_8bits
- ADDR_W, 2, register address width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset; sampled on rising edge of clk
- freeze  in  1  1 = grant nothing this cycle (CPU halt/debug)
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid[i] & ready[i]
- reg_d  out  DATA_W  shared D bus to all registers
- reg_en  out  NUM_REGS  one-hot enable bus to register_8bits.enable
- addr_err  out  1  one-cycle pulse; a granted write targeted addr >= NUM_REGS

## Operation
- Round-robin pointer ptr in range 0..NUM_REQ-1. Priority order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
- Winner w is the first index in priority order with req_valid set. req_ready is driven combinationally, with ready[w]=1 and all other bits 0.
- req_ready is forced to 0 when freeze=1, when rst=0, or when no request is valid.
- On a transfer, at the next edge:
  - ptr updates to (w+1) mod NUM_REQ.
  - reg_d captures req_data of w.
  - reg_en captures one-hot(req_addr of w).
- If the granted address is >= NUM_REGS:
  - reg_en captures all zeros and addr_err captures 1.
  - The grant is still consumed and ptr still advances.
- With no transfer: reg_en captures 0, addr_err captures 0, reg_d holds its value, ptr holds its value.
- Requesters hold valid, addr and data stable until they see ready. The block never drops a granted write.
- Pipeline FSM is implicit: output stage IDLE (reg_en=0) or WRITE (reg_en one-hot). Each transfer produces exactly one WRITE cycle.

## Timing
- Reset values: reg_d=0, reg_en=0, addr_err=0, ptr=0, req_ready=0 while rst=0.
- Latency: transfer in cycle N, then reg_en/reg_d valid during cycle N+1, then register_8bits output updated after edge ending N+1.
- Throughput: one transfer per cycle, with back-to-back grants and no bubbles.
- Two requesters writing the same address on consecutive cycles: both writes occur in grant order, and the later one wins.
- freeze rising in cycle N: no transfer in N, and reg_en=0 in N+1. A transfer from cycle N-1 still completes its WRITE in N.
- Reset asserted mid-stream: any write already registered (reg_en set) is cleared at the reset edge and does not occur. Requesters must re-present their requests.
- req_valid deasserted without ready is legal and causes no side effects.

## Structure
- Shared package sisa_pkg holds DATA_W, ADDR_W, NUM_REGS defaults and the requester index constants REQ_ALU=0, REQ_MEM=1, REQ_IMM=2.
- Sub-module rr_arbiter:
  - inputs clk, rst, req[NUM_REQ], advance.
  - outputs grant_onehot, grant_idx.
  - owns ptr.
- The top level owns the data/address muxes, address decode and the output register stage.

## Test plan
- Reset with valid=3'b111 held: req_ready=0, reg_en=0, reg_d=0 throughout reset. After release, first grant goes to requester 0.
- Continuous contention, valid=3'b111, addr0=1/addr1=2/addr2=3, data A0/B1/C2: grants rotate 0,1,2,0. reg_en sequence is 0010, 0100, 1000, 0010, one cycle after each grant.
- Single requester 2 writing 8'h5A to addr 0: ready[2] in cycle N. reg_en=0001 and reg_d=8'h5A in N+1. Register 0 reads 8'h5A after that edge.
- NUM_REGS=3, requester 1 writes addr 3: ready[1] granted, reg_en=000, addr_err pulses 1 for one cycle. ptr advances so requester 2 wins next.
- freeze=1 for 2 cycles with valid=3'b011: no ready, and reg_en=0 after the first frozen cycle. On release, the grant resumes at the unchanged ptr.
- rst low in the cycle after a grant to addr 2: reg_en is 0 at the following edge and register 2 is unchanged.
